shell_judge: RTL and testbench
==============================

SHELL_JUDGE -- requirements
Module: shell_judge

Interface
REQ-001 SHALL have parameter COOLDOWN, default 20'd2000000, minimum clk cycles between accepted fires per tank.
REQ-002 SHALL have parameter LIVES_INIT, default 2'd3, lives per tank after reset.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset; rst_n, synchronous, active-low; clock clk.
REQ-005 fire_1, fire_2  input  1 each  player fire request, level.
REQ-006 shell_1_x_pos, shell_1_y_pos, shell_2_x_pos, shell_2_y_pos  input  30 each  five 6-bit fields; shell i = bits [6i+5:6i].
REQ-007 valid_1_shell, valid_2_shell  input  5 each  1 = shell idle/available, 0 = in flight.
REQ-008 tank_1_x_pos, tank_1_y_pos, tank_2_x_pos, tank_2_y_pos  input  6 each  tank tile.
REQ-009 map_x, map_y  output  6 each  wall-map read address.
REQ-010 map_wall  input  1  wall flag, valid exactly 1 cycle after address presented.
REQ-011 vanish_1, vanish_2  output  5 each  one-cycle kill pulse per shell.
REQ-012 valid_give_shell_1, valid_give_shell_2  output  1 each  fire permitted.
REQ-013 hit_1, hit_2  output  1 each  one-cycle pulse: that tank was hit.
REQ-014 lives_1, lives_2  output  2 each  remaining lives.
REQ-015 game_over  output  1  sticky end-of-game flag.
REQ-016 winner  output  2  01 tank 1, 10 tank 2, 11 draw, 00 undecided.

Function
REQ-017 Scan FSM SHALL cycle IDLE -> REQ -> CHK -> ... -> DONE -> IDLE, visiting shell index 0..9 (0-4 tank 1, 5-9 tank 2) in order, restarting the cycle after DONE.
REQ-018 IDLE SHALL last 1 cycle; DONE SHALL last 1 cycle.
REQ-019 REQ: shell idle (valid=1) -> next index, no map access, 1 cycle; in flight -> latch x,y, drive map_x/map_y = latched x,y, go CHK.
REQ-020 CHK: vanish if out of field (x >= FIELD_W or y >= FIELD_H, covers 0-1 wrap to 63), else enemy tank tile equal, else map_wall = 1; priority in that order.
REQ-021 Vanish pulse SHALL assert in the CHK cycle, one cycle, only for the checked shell; never for an idle shell.
REQ-022 Enemy-tank hit SHALL additionally pulse hit_n of the struck tank same cycle and decrement its lives, saturating at 0.
REQ-023 Own-tank coincidence SHALL NOT vanish or hit.
REQ-024 In DONE, if either lives = 0 and game_over = 0: set game_over, winner per REQ-016 (both 0 -> 11).
REQ-025 Hits in same scan round on both tanks SHALL both count; resolution only at DONE.
REQ-026 game_over = 1: scanning continues, vanishing shells; hit pulses and lives frozen.
REQ-027 valid_give_shell_n = 1 iff cooldown counter n is 0 and game_over = 0 and |valid_n_shell.
REQ-028 Fire accepted when fire_n & valid_give_shell_n; counter loads COOLDOWN-1 next cycle, decrements to 0; valid_give drops the cycle after acceptance.
REQ-029 map_x/map_y SHALL hold last value outside REQ.

Reset
REQ-030 On rst_n=0 at clk edge: FSM IDLE, index 0, vanish 0, hit 0, lives = LIVES_INIT, game_over 0, winner 00, cooldown counters 0, map_x/map_y 0.
REQ-031 Reset mid-scan SHALL abort scan with no vanish/hit pulse in the reset cycle.

Structure
REQ-032 Package shell_pkg SHALL hold FIELD_W = 40, FIELD_H = 30, scan-state enum, winner encodings.
REQ-033 Cooldown logic SHALL be sub-module fire_gate, instantiated per tank.

Verification
REQ-034 Shell 1_2 in flight at (10,10), map_wall=1 for (10,10) -> vanish_1 = 00100 one cycle in its CHK, lives unchanged.
REQ-035 Shell 2_0 at (5,7), tank 1 at (5,7), wall 0 -> vanish_2 = 00001, hit_1 pulse, lives_1 3->2.
REQ-036 Shell 1_0 at x=63 (wrapped) -> vanish_1[0], no map-dependent outcome, no hit.
REQ-037 lives 1/1, both tanks hit in one round -> at DONE game_over=1, winner=11; later hits ignored.
REQ-038 COOLDOWN=4, fire_1 held high -> valid_give_shell_1 pattern 1,0,0,0,0,1; all valid_1_shell=0 -> 0.
REQ-039 rst_n low during CHK with pending wall hit -> no vanish, all outputs at reset values next cycle.

Source files
------------

// File: rtl/shell_pkg.sv
// Shared constants and types for the shell judge.
// Field size, scan states and winner codes live here.
package shell_pkg;

    localparam int unsigned FIELD_W = 40;
    localparam int unsigned FIELD_H = 30;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CHK,
        S_DONE
    } scan_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_T1   = 2'b01;
    localparam logic [1:0] WIN_T2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic in_field(logic [5:0] x, logic [5:0] y);
        return (x < 6'(FIELD_W)) && (y < 6'(FIELD_H));
    endfunction

    function automatic logic [1:0] pick_winner(logic dead1, logic dead2);
        logic [1:0] w;
        w = WIN_NONE;
        if (dead1 && dead2) w = WIN_DRAW;
        else if (dead1)     w = WIN_T2;
        else if (dead2)     w = WIN_T1;
        return w;
    endfunction

endpackage

// File: rtl/shell_judge_fire_gate.sv
// Per-tank fire permission with a post-acceptance cooldown.
// The counter is loaded the cycle after a fire is accepted.
module fire_gate #(
    parameter logic [19:0] COOLDOWN = 20'd2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fire_i,
    input  logic avail_i,
    input  logic halt_i,
    output logic give_o
);

    localparam logic [19:0] RELOAD = (COOLDOWN == 20'd0) ? 20'd0
                                                         : COOLDOWN - 20'd1;

    logic [19:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        take;

    assign give_o = (cnt_q == 20'd0) && !pend_q && !halt_i && avail_i;
    assign take   = fire_i && give_o;

    always_comb begin
        pend_d = take;
        cnt_d  = cnt_q;
        if (pend_q)
            cnt_d = RELOAD;
        else if (cnt_q != 20'd0)
            cnt_d = cnt_q - 20'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 20'd0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/shell_judge.sv
// Shell collision judge: scans ten shells against field edge,
// enemy tank and wall map; tracks lives, game over and winner.
module shell_judge
    import shell_pkg::*;
#(
    parameter logic [19:0] COOLDOWN   = 20'd2000000,
    parameter logic [1:0]  LIVES_INIT = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fire_1,
    input  logic        fire_2,
    input  logic [29:0] shell_1_x_pos,
    input  logic [29:0] shell_1_y_pos,
    input  logic [29:0] shell_2_x_pos,
    input  logic [29:0] shell_2_y_pos,
    input  logic [4:0]  valid_1_shell,
    input  logic [4:0]  valid_2_shell,
    input  logic [5:0]  tank_1_x_pos,
    input  logic [5:0]  tank_1_y_pos,
    input  logic [5:0]  tank_2_x_pos,
    input  logic [5:0]  tank_2_y_pos,
    output logic [5:0]  map_x,
    output logic [5:0]  map_y,
    input  logic        map_wall,
    output logic [4:0]  vanish_1,
    output logic [4:0]  vanish_2,
    output logic        valid_give_shell_1,
    output logic        valid_give_shell_2,
    output logic        hit_1,
    output logic        hit_2,
    output logic [1:0]  lives_1,
    output logic [1:0]  lives_2,
    output logic        game_over,
    output logic [1:0]  winner
);

    scan_e       state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [5:0]  mapx_q, mapy_q;
    logic [1:0]  lives1_q, lives2_q;
    logic        go_q;
    logic [1:0]  win_q;

    logic [9:0]  busy_all;
    logic [59:0] sx_all, sy_all;
    logic [5:0]  base;
    logic [5:0]  cur_x, cur_y;
    logic        cur_busy;
    logic        last_idx;
    logic        from_t1;
    logic [5:0]  enemy_x, enemy_y;
    logic        req_busy;
    logic [9:0]  van;

    assign busy_all = ~{valid_2_shell, valid_1_shell};
    assign sx_all   = {shell_2_x_pos, shell_1_x_pos};
    assign sy_all   = {shell_2_y_pos, shell_1_y_pos};
    assign base     = {idx_q, 2'b00} + {1'b0, idx_q, 1'b0};
    assign cur_x    = sx_all[base +: 6];
    assign cur_y    = sy_all[base +: 6];
    assign cur_busy = busy_all[idx_q];
    assign last_idx = (idx_q == 4'd9);
    assign from_t1  = (idx_q < 4'd5);
    assign enemy_x  = from_t1 ? tank_2_x_pos : tank_1_x_pos;
    assign enemy_y  = from_t1 ? tank_2_y_pos : tank_1_y_pos;
    assign req_busy = (state_q == S_REQ) && cur_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                idx_d   = 4'd0;
            end
            S_REQ: begin
                if (cur_busy)
                    state_d = S_CHK;
                else if (last_idx)
                    state_d = S_DONE;
                else
                    idx_d = idx_q + 4'd1;
            end
            S_CHK: begin
                if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                    idx_d   = idx_q + 4'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // CHK judges the address latched in REQ; map_wall belongs to it
    always_comb begin
        van   = 10'd0;
        hit_1 = 1'b0;
        hit_2 = 1'b0;
        map_x = mapx_q;
        map_y = mapy_q;
        if (req_busy) begin
            map_x = cur_x;
            map_y = cur_y;
        end
        if (state_q == S_CHK && rst_n) begin
            if (!in_field(mapx_q, mapy_q)) begin
                van[idx_q] = 1'b1;
            end else if (mapx_q == enemy_x && mapy_q == enemy_y) begin
                van[idx_q] = 1'b1;
                hit_2      = from_t1 && !go_q;
                hit_1      = !from_t1 && !go_q;
            end else if (map_wall) begin
                van[idx_q] = 1'b1;
            end
        end
    end

    assign vanish_1 = van[4:0];
    assign vanish_2 = van[9:5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mapx_q   <= 6'd0;
            mapy_q   <= 6'd0;
            lives1_q <= LIVES_INIT;
            lives2_q <= LIVES_INIT;
            go_q     <= 1'b0;
            win_q    <= WIN_NONE;
        end else begin
            if (req_busy) begin
                mapx_q <= cur_x;
                mapy_q <= cur_y;
            end
            if (hit_1 && lives1_q != 2'd0)
                lives1_q <= lives1_q - 2'd1;
            if (hit_2 && lives2_q != 2'd0)
                lives2_q <= lives2_q - 2'd1;
            if (state_q == S_DONE && !go_q &&
                (lives1_q == 2'd0 || lives2_q == 2'd0)) begin
                go_q  <= 1'b1;
                win_q <= pick_winner(lives1_q == 2'd0, lives2_q == 2'd0);
            end
        end
    end

    assign lives_1   = lives1_q;
    assign lives_2   = lives2_q;
    assign game_over = go_q;
    assign winner    = win_q;

    fire_gate #(.COOLDOWN(COOLDOWN)) u_gate_1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .fire_i  (fire_1),
        .avail_i (|valid_1_shell),
        .halt_i  (go_q),
        .give_o  (valid_give_shell_1)
    );

    fire_gate #(.COOLDOWN(COOLDOWN)) u_gate_2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .fire_i  (fire_2),
        .avail_i (|valid_2_shell),
        .halt_i  (go_q),
        .give_o  (valid_give_shell_2)
    );

endmodule

// File: tb/tb_shell_judge.sv
// Bench for shell_judge: directed table, corner sequences and
// randomized rounds against a round-level reference model.
module tb_shell_judge;

    localparam logic [19:0] CD = 20'd4;
    localparam int          LI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fire_1 = 1'b0, fire_2 = 1'b0;
    logic [29:0] s1x = '0, s1y = '0, s2x = '0, s2y = '0;
    logic [4:0]  v1 = '1, v2 = '1;
    logic [5:0]  t1x = '0, t1y = '0, t2x = '0, t2y = '0;
    logic [5:0]  map_x, map_y;
    logic        map_wall = 1'b0;
    logic [4:0]  vanish_1, vanish_2;
    logic        give_1, give_2, hit_1, hit_2;
    logic [1:0]  lives_1, lives_2;
    logic        game_over;
    logic [1:0]  winner;

    bit wall [0:4095];

    shell_judge #(.COOLDOWN(CD), .LIVES_INIT(2'd3)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fire_1             (fire_1),
        .fire_2             (fire_2),
        .shell_1_x_pos      (s1x),
        .shell_1_y_pos      (s1y),
        .shell_2_x_pos      (s2x),
        .shell_2_y_pos      (s2y),
        .valid_1_shell      (v1),
        .valid_2_shell      (v2),
        .tank_1_x_pos       (t1x),
        .tank_1_y_pos       (t1y),
        .tank_2_x_pos       (t2x),
        .tank_2_y_pos       (t2y),
        .map_x              (map_x),
        .map_y              (map_y),
        .map_wall           (map_wall),
        .vanish_1           (vanish_1),
        .vanish_2           (vanish_2),
        .valid_give_shell_1 (give_1),
        .valid_give_shell_2 (give_2),
        .hit_1              (hit_1),
        .hit_2              (hit_2),
        .lives_1            (lives_1),
        .lives_2            (lives_2),
        .game_over          (game_over),
        .winner             (winner)
    );

    always #5 clk = ~clk;

    // wall memory answers one cycle after the address
    always @(posedge clk) map_wall <= wall[{map_x, map_y}];

    int n_cmp = 0;
    int n_err = 0;

    int          m_l1, m_l2;
    bit          m_go;
    logic [1:0]  m_win;
    logic [5:0]  m_mx, m_my;
    longint      cyc = 0, last1, last2;
    logic [4:0]  a_v1, a_v2;
    bit          a_h1, a_h2;

    typedef struct {
        int idx; int x; int y;
        int t1x; int t1y; int t2x; int t2y;
        bit w;
        logic [4:0] ev1; logic [4:0] ev2;
        bit eh1; bit eh2;
        int el1; int el2;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_l1 = LI; m_l2 = LI; m_go = 0; m_win = 2'b00;
        m_mx = 0; m_my = 0;
        last1 = cyc - 100; last2 = cyc - 100;
    endtask

    task automatic do_reset();
        rst_n = 0; fire_1 = 0; fire_2 = 0;
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic spos(int i, output logic [5:0] x, output logic [5:0] y);
        if (i < 5) begin
            x = s1x[6*i +: 6]; y = s1y[6*i +: 6];
        end else begin
            x = s2x[6*(i-5) +: 6]; y = s2y[6*(i-5) +: 6];
        end
    endtask

    task automatic sset(int i, logic [5:0] x, logic [5:0] y);
        if (i < 5) begin
            s1x[6*i +: 6] = x; s1y[6*i +: 6] = y;
        end else begin
            s2x[6*(i-5) +: 6] = x; s2y[6*(i-5) +: 6] = y;
        end
    endtask

    // One full scan from IDLE to DONE; the slot list follows the
    // timing rules: 1 cycle per idle shell, 2 per in-flight shell.
    task automatic round(input bit rnd);
        int q[$];
        logic [9:0] va;
        logic [5:0] x, y, ex, ey, emx, emy;
        logic [4:0] e1, e2;
        bit eh1, eh2, van, eg1, eg2;
        int code, i;
        va = {v2, v1};
        x = 0; y = 0; i = 0;
        q.push_back(-1);
        for (int k = 0; k < 10; k++) begin
            if (va[k]) q.push_back(k);
            else begin q.push_back(100 + k); q.push_back(200 + k); end
        end
        q.push_back(-2);
        a_v1 = 0; a_v2 = 0; a_h1 = 0; a_h2 = 0;
        foreach (q[k]) begin
            code = q[k];
            e1 = 0; e2 = 0; eh1 = 0; eh2 = 0; van = 0;
            emx = m_mx; emy = m_my;
            if (rnd) begin
                fire_1 = ($urandom_range(0, 2) == 0);
                fire_2 = ($urandom_range(0, 2) == 0);
            end
            if (code >= 100) begin
                i = code % 100;
                spos(i, x, y);
            end
            if (code >= 100 && code < 200) begin
                emx = x; emy = y;
            end
            if (code >= 200) begin
                ex = (i < 5) ? t2x : t1x;
                ey = (i < 5) ? t2y : t1y;
                if (x >= 40 || y >= 30) van = 1;
                else if (x == ex && y == ey) begin
                    van = 1;
                    if (!m_go) begin
                        if (i < 5) eh2 = 1; else eh1 = 1;
                    end
                end else van = wall[{x, y}];
                if (i < 5) e1[i] = van; else e2[i-5] = van;
            end
            eg1 = (cyc - last1 > longint'(CD)) && !m_go && (|v1);
            eg2 = (cyc - last2 > longint'(CD)) && !m_go && (|v2);
            @(negedge clk);
            chk("vanish_1", vanish_1, e1);
            chk("vanish_2", vanish_2, e2);
            chk("hit_1", hit_1, eh1);
            chk("hit_2", hit_2, eh2);
            chk("map_x", map_x, emx);
            chk("map_y", map_y, emy);
            chk("lives_1", lives_1, m_l1);
            chk("lives_2", lives_2, m_l2);
            chk("game_over", game_over, m_go);
            chk("winner", winner, m_win);
            chk("give_1", give_1, eg1);
            chk("give_2", give_2, eg2);
            a_v1 |= vanish_1; a_v2 |= vanish_2;
            a_h1 |= hit_1; a_h2 |= hit_2;
            if (fire_1 && eg1) last1 = cyc;
            if (fire_2 && eg2) last2 = cyc;
            if (eh1 && m_l1 > 0) m_l1--;
            if (eh2 && m_l2 > 0) m_l2--;
            if (code >= 100 && code < 200) begin m_mx = x; m_my = y; end
            if (code == -2 && !m_go && (m_l1 == 0 || m_l2 == 0)) begin
                m_go = 1;
                m_win = (m_l1 == 0 && m_l2 == 0) ? 2'b11 :
                        (m_l1 == 0) ? 2'b10 : 2'b01;
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] pat;
        tbl[0] = '{2, 10, 10,  1, 1,  2,  2, 1, 5'b00100, 5'b00000, 0, 0, 3, 3};
        tbl[1] = '{5,  5,  7,  5, 7,  2,  2, 0, 5'b00000, 5'b00001, 1, 0, 2, 3};
        tbl[2] = '{0, 63,  5,  1, 1, 63,  5, 1, 5'b00001, 5'b00000, 0, 0, 2, 3};
        tbl[3] = '{1,  4,  4,  4, 4,  2,  2, 0, 5'b00000, 5'b00000, 0, 0, 2, 3};
        tbl[4] = '{9, 39, 29,  1, 1,  2,  2, 0, 5'b00000, 5'b00000, 0, 0, 2, 3};
        tbl[5] = '{6, 20, 30,  1, 1,  2,  2, 0, 5'b00000, 5'b00010, 0, 0, 2, 3};
        tbl[6] = '{3, 40,  0,  1, 1,  2,  2, 0, 5'b01000, 5'b00000, 0, 0, 2, 3};
        tbl[7] = '{7,  8,  8,  8, 8,  2,  2, 1, 5'b00000, 5'b00100, 1, 0, 1, 3};
        tbl[8] = '{4, 12, 13,  1, 1, 12, 13, 0, 5'b10000, 5'b00000, 0, 1, 1, 2};
        tbl[9] = '{0, 30, 20,  1, 1,  2,  2, 0, 5'b00000, 5'b00000, 0, 0, 1, 2};

        for (int w = 0; w < 4096; w++) wall[w] = 0;
        do_reset();
        @(negedge clk);
        chk("rst_lives_1", lives_1, 3);
        chk("rst_lives_2", lives_2, 3);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        chk("rst_map_x", map_x, 0);
        chk("rst_vanish", {vanish_2, vanish_1}, 0);
        do_reset();

        foreach (tbl[n]) begin
            s1x = '0; s1y = '0; s2x = '0; s2y = '0;
            v1 = '1; v2 = '1;
            sset(tbl[n].idx, 6'(tbl[n].x), 6'(tbl[n].y));
            if (tbl[n].idx < 5) v1[tbl[n].idx] = 1'b0;
            else v2[tbl[n].idx - 5] = 1'b0;
            t1x = 6'(tbl[n].t1x); t1y = 6'(tbl[n].t1y);
            t2x = 6'(tbl[n].t2x); t2y = 6'(tbl[n].t2y);
            wall[{6'(tbl[n].x), 6'(tbl[n].y)}] = tbl[n].w;
            round(0);
            chk($sformatf("tbl%0d_vanish_1", n), a_v1, tbl[n].ev1);
            chk($sformatf("tbl%0d_vanish_2", n), a_v2, tbl[n].ev2);
            chk($sformatf("tbl%0d_hit_1", n), a_h1, tbl[n].eh1);
            chk($sformatf("tbl%0d_hit_2", n), a_h2, tbl[n].eh2);
            chk($sformatf("tbl%0d_lives_1", n), lives_1, tbl[n].el1);
            chk($sformatf("tbl%0d_lives_2", n), lives_2, tbl[n].el2);
            wall[{6'(tbl[n].x), 6'(tbl[n].y)}] = 0;
        end

        // mutual hits every round: draw once both reach zero
        do_reset();
        v1 = 5'b11110; v2 = 5'b11110;
        t1x = 6; t1y = 6; t2x = 9; t2y = 9;
        sset(0, 6'd9, 6'd9);
        sset(5, 6'd6, 6'd6);
        round(0);
        round(0);
        chk("draw_l1_before", lives_1, 1);
        chk("draw_l2_before", lives_2, 1);
        chk("draw_go_before", game_over, 0);
        round(0);
        chk("draw_go", game_over, 1);
        chk("draw_winner", winner, 2'b11);
        chk("draw_lives", {lives_1, lives_2}, 0);
        round(0);
        chk("over_hits", {a_h1, a_h2}, 0);
        chk("over_vanish", {a_v2, a_v1}, 10'b00001_00001);
        chk("over_winner", winner, 2'b11);

        // cooldown with fire held high
        do_reset();
        v1 = 5'h1f;
        fire_1 = 1;
        pat = 5'b00001;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("cool_give_%0d", j), give_1,
                (j == 0 || j == 5) ? 1 : 0);
            @(posedge clk); #1;
        end
        v1 = 5'b00000;
        #1;
        chk("cool_all_busy", give_1, 0);
        fire_1 = 0;
        v1 = pat;
        do_reset();

        // reset lands on a CHK that would vanish on a wall
        v1 = 5'b11110; v2 = '1;
        sset(0, 6'd3, 6'd3);
        wall[{6'd3, 6'd3}] = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_vanish", vanish_1, 5'b00001);
        @(posedge clk); #1;
        do_reset();
        chk("rst2_map_x", map_x, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        @(negedge clk);
        chk("rst_cycle_vanish", vanish_1, 0);
        chk("rst_cycle_hit", {hit_1, hit_2}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        chk("rst2_vanish", {vanish_2, vanish_1}, 0);
        chk("rst2_map", {map_x, map_y}, 0);
        chk("rst2_lives", {lives_1, lives_2}, 4'b1111);
        chk("rst2_go_win", {game_over, winner}, 0);
        wall[{6'd3, 6'd3}] = 0;

        for (int r = 0; r < 160; r++) begin
            if (r % 40 == 0) begin
                do_reset();
                for (int w = 0; w < 4096; w++)
                    wall[w] = ($urandom_range(0, 3) == 0);
            end
            t1x = 6'($urandom_range(0, 7)); t1y = 6'($urandom_range(0, 7));
            t2x = 6'($urandom_range(0, 7)); t2y = 6'($urandom_range(0, 7));
            v1 = 5'($urandom); v2 = 5'($urandom);
            for (int k = 0; k < 10; k++) begin
                int c;
                logic [5:0] x, y;
                c = $urandom_range(0, 5);
                if (c == 0) begin
                    x = (k < 5) ? t2x : t1x; y = (k < 5) ? t2y : t1y;
                end else if (c == 1) begin
                    x = (k < 5) ? t1x : t2x; y = (k < 5) ? t1y : t2y;
                end else if (c == 2) begin
                    x = 6'($urandom); y = 6'($urandom);
                end else begin
                    x = 6'($urandom_range(0, 45));
                    y = 6'($urandom_range(0, 35));
                end
                sset(k, x, y);
            end
            round(1);
        end
        fire_1 = 0; fire_2 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
